// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequences one ALU operation at a time. Serialises rs1 then rs2 (or the
// immediate) onto the ALU operand bus, waits for the result under a timeout and holds it
// on a valid/ready response channel.
module alu_issue_ctrl #(
  parameter int unsigned BUS_WIDTH      = 32,
  parameter int unsigned OPCODE_WIDTH   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [OPCODE_WIDTH-1:0] req_op_code,
  input  logic [BUS_WIDTH-1:0]    req_rs1,
  input  logic [BUS_WIDTH-1:0]    req_rs2,
  input  logic [BUS_WIDTH-1:0]    req_imm,
  input  logic                    req_use_imm,
  output logic [BUS_WIDTH-1:0]    imme_value,
  output logic [BUS_WIDTH-1:0]    rs_data,
  output logic                    rs_data_sel,
  output logic                    rs_data_valid,
  output logic [OPCODE_WIDTH-1:0] op_code,
  input  logic [BUS_WIDTH-1:0]    alu_out,
  input  logic                    alu_valid_out,
  output logic                    op_done,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [BUS_WIDTH-1:0]    rsp_data,
  output logic                    rsp_timeout
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StSendRs1, StSendRs2, StWaitRes, StResp} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [OPCODE_WIDTH-1:0] op_q, op_d;
  logic [BUS_WIDTH-1:0]    rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
  logic                    use_imm_q, use_imm_d;

  // Next values of the registered outputs, derived from the next state.
  logic                    req_ready_d, rs_data_sel_d, rs_data_valid_d, op_done_d;
  logic                    rsp_valid_d, rsp_timeout_d;
  logic [BUS_WIDTH-1:0]    imme_value_d, rs_data_d, rsp_data_d;
  logic [OPCODE_WIDTH-1:0] op_code_d;

  // Next-state, request latching, result capture and timeout counting.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    imm_d         = imm_q;
    use_imm_d     = use_imm_q;
    rsp_data_d    = rsp_data;
    rsp_timeout_d = rsp_timeout;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d      = req_op_code;
          rs1_d     = req_rs1;
          rs2_d     = req_rs2;
          imm_d     = req_imm;
          use_imm_d = req_use_imm;
          state_d   = StSendRs1;
        end
      end
      StSendRs1: begin
        cnt_d   = '0;
        state_d = use_imm_q ? StWaitRes : StSendRs2;
      end
      StSendRs2: begin
        cnt_d   = '0;
        state_d = StWaitRes;
      end
      StWaitRes: begin
        // A result arriving in the final count cycle still wins over the timeout.
        if (alu_valid_out) begin
          rsp_data_d    = alu_out;
          rsp_timeout_d = 1'b0;
          state_d       = StResp;
        end else if (cnt_q == CntLast) begin
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
          state_d       = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b0;
          cnt_d         = '0;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the next state so every output comes straight from a flop.
  always_comb begin
    req_ready_d     = (state_d == StIdle);
    rs_data_valid_d = (state_d == StSendRs1) || (state_d == StSendRs2);
    rs_data_sel_d   = (state_d == StSendRs2);
    rs_data_d       = '0;
    if (state_d == StSendRs1) rs_data_d = rs1_d;
    if (state_d == StSendRs2) rs_data_d = rs2_d;
    op_code_d       = '0;
    imme_value_d    = '0;
    if (rs_data_valid_d || (state_d == StWaitRes)) begin
      op_code_d = op_d;
      if (use_imm_d) imme_value_d = imm_d;
    end
    rsp_valid_d = (state_d == StResp);
    op_done_d   = (state_d == StResp) && (state_q == StWaitRes);
  end

  // State, latched request fields and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      op_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      imm_q         <= '0;
      use_imm_q     <= 1'b0;
      req_ready     <= 1'b1;
      imme_value    <= '0;
      rs_data       <= '0;
      rs_data_sel   <= 1'b0;
      rs_data_valid <= 1'b0;
      op_code       <= '0;
      op_done       <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_timeout   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      imm_q         <= imm_d;
      use_imm_q     <= use_imm_d;
      req_ready     <= req_ready_d;
      imme_value    <= imme_value_d;
      rs_data       <= rs_data_d;
      rs_data_sel   <= rs_data_sel_d;
      rs_data_valid <= rs_data_valid_d;
      op_code       <= op_code_d;
      op_done       <= op_done_d;
      rsp_valid     <= rsp_valid_d;
      rsp_data      <= rsp_data_d;
      rsp_timeout   <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: inputs change and outputs are sampled on the falling
// edge; the DUT acts on the rising edge.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_use_imm;
  logic [3:0]  req_op_code, op_code;
  logic [31:0] req_rs1, req_rs2, req_imm;
  logic [31:0] imme_value, rs_data, alu_out, rsp_data;
  logic        rs_data_sel, rs_data_valid, alu_valid_out, op_done;
  logic        rsp_valid, rsp_ready, rsp_timeout;

  int n_checks = 0;
  int n_pass   = 0;

  alu_issue_ctrl #(
    .BUS_WIDTH     (32),
    .OPCODE_WIDTH  (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op_code  (req_op_code),
    .req_rs1      (req_rs1),
    .req_rs2      (req_rs2),
    .req_imm      (req_imm),
    .req_use_imm  (req_use_imm),
    .imme_value   (imme_value),
    .rs_data      (rs_data),
    .rs_data_sel  (rs_data_sel),
    .rs_data_valid(rs_data_valid),
    .op_code      (op_code),
    .alu_out      (alu_out),
    .alu_valid_out(alu_valid_out),
    .op_done      (op_done),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_timeout  (rsp_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present a request for one cycle (accepted on the following rising edge).
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic use_imm);
    req_valid   = 1'b1;
    req_op_code = op;
    req_rs1     = a;
    req_rs2     = b;
    req_imm     = imm;
    req_use_imm = use_imm;
    step();
    req_valid = 1'b0;
  endtask

  logic [31:0] tbl_a [3];
  logic [31:0] tbl_b [3];
  logic [31:0] tbl_e [3];

  initial begin
    int wait_cnt, done_cnt, seen, idx, n_rsp, pend;
    logic [31:0] cap_a, cap_b;
    rst_n = 1'b0; req_valid = 1'b0; req_op_code = '0; req_rs1 = '0; req_rs2 = '0;
    req_imm = '0; req_use_imm = 1'b0; alu_out = '0; alu_valid_out = 1'b0; rsp_ready = 1'b1;
    #12;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rs_valid", {31'b0, rs_data_valid}, 32'd0);
    check("rst_op_code", {28'b0, op_code}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Register form: 5 + 7 = 12, ALU answers in the first WAIT_RES cycle.
    issue(4'h1, 32'd5, 32'd7, 32'd0, 1'b0);
    check("reg_rs1_valid", {31'b0, rs_data_valid}, 32'd1);
    check("reg_rs1_data", rs_data, 32'd5);
    check("reg_rs1_sel", {31'b0, rs_data_sel}, 32'd0);
    check("reg_op_code", {28'b0, op_code}, 32'd1);
    check("reg_busy", {31'b0, req_ready}, 32'd0);
    step();
    check("reg_rs2_data", rs_data, 32'd7);
    check("reg_rs2_sel", {31'b0, rs_data_sel}, 32'd1);
    check("reg_rs2_valid", {31'b0, rs_data_valid}, 32'd1);
    step();
    check("reg_wait_valid", {31'b0, rs_data_valid}, 32'd0);
    check("reg_wait_op", {28'b0, op_code}, 32'd1);
    check("reg_wait_imm", imme_value, 32'd0);
    alu_valid_out = 1'b1; alu_out = 32'd12;
    step();
    alu_valid_out = 1'b0;
    check("reg_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("reg_rsp_data", rsp_data, 32'd12);
    check("reg_rsp_to", {31'b0, rsp_timeout}, 32'd0);
    check("reg_op_done", {31'b0, op_done}, 32'd1);
    check("reg_resp_op", {28'b0, op_code}, 32'd0);
    step();
    check("reg_idle_rsp", {31'b0, rsp_valid}, 32'd0);
    check("reg_idle_done", {31'b0, op_done}, 32'd0);
    check("reg_idle_ready", {31'b0, req_ready}, 32'd1);

    // Immediate form; a stray result during SEND_RS1 must be ignored.
    issue(4'h2, 32'hFFFF_FFFF, 32'h5555_5555, 32'd1, 1'b1);
    check("imm_rs1_valid", {31'b0, rs_data_valid}, 32'd1);
    check("imm_rs1_sel", {31'b0, rs_data_sel}, 32'd0);
    check("imm_rs1_data", rs_data, 32'hFFFF_FFFF);
    check("imm_value_s", imme_value, 32'd1);
    alu_valid_out = 1'b1; alu_out = 32'hDEAD_BEEF;
    step();
    check("imm_one_send", {31'b0, rs_data_valid}, 32'd0);
    check("imm_value_w", imme_value, 32'd1);
    check("imm_no_early", {31'b0, rsp_valid}, 32'd0);
    alu_out = 32'd0;
    step();
    alu_valid_out = 1'b0;
    check("imm_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("imm_rsp_data", rsp_data, 32'd0);
    check("imm_op_done", {31'b0, op_done}, 32'd1);
    check("imm_resp_imm", imme_value, 32'd0);
    step();

    // Timeout: no result ever; count WAIT_RES cycles (op_code live, no operand valid).
    issue(4'h3, 32'd1, 32'd2, 32'd9, 1'b1);
    wait_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (rsp_valid) break;
      if (op_code == 4'h3 && !rs_data_valid) wait_cnt++;
      step();
    end
    check("to_resp", {31'b0, rsp_valid}, 32'd1);
    check("to_wait_cycles", wait_cnt, 32'd16);
    check("to_flag", {31'b0, rsp_timeout}, 32'd1);
    check("to_data", rsp_data, 32'd0);
    check("to_op_done", {31'b0, op_done}, 32'd1);
    step();

    // Result in the very last WAIT_RES cycle beats the timeout.
    issue(4'h3, 32'd1, 32'd2, 32'd9, 1'b1);
    for (int k = 0; k < 16; k++) step();
    check("last_not_yet", {31'b0, rsp_valid}, 32'd0);
    alu_valid_out = 1'b1; alu_out = 32'h0000_ABCD;
    step();
    alu_valid_out = 1'b0;
    check("last_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("last_data", rsp_data, 32'h0000_ABCD);
    check("last_no_to", {31'b0, rsp_timeout}, 32'd0);
    step();

    // Backpressure: hold RESP for 5 cycles with a stray result arriving meanwhile.
    rsp_ready = 1'b0;
    issue(4'h2, 32'd3, 32'd4, 32'd0, 1'b0);
    step();
    step();
    alu_valid_out = 1'b1; alu_out = 32'd7;
    step();
    alu_valid_out = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid%0d", i), {31'b0, rsp_valid}, 32'd1);
      check($sformatf("bp_data%0d", i), rsp_data, 32'd7);
      check($sformatf("bp_ready%0d", i), {31'b0, req_ready}, 32'd0);
      if (op_done) done_cnt++;
      alu_valid_out = (i == 1); alu_out = 32'd99;
      step();
    end
    check("bp_done_once", done_cnt, 32'd1);
    rsp_ready = 1'b1;
    step();
    check("bp_release", {31'b0, rsp_valid}, 32'd0);
    check("bp_idle", {31'b0, req_ready}, 32'd1);

    // Reset asserted while rs2 is on the bus aborts with no response.
    issue(4'h1, 32'd8, 32'd9, 32'd0, 1'b0);
    step();
    check("rr_in_rs2", {31'b0, rs_data_sel}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rr_async_valid", {31'b0, rs_data_valid}, 32'd0);
    check("rr_async_data", rs_data, 32'd0);
    check("rr_async_op", {28'b0, op_code}, 32'd0);
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (rsp_valid) seen++;
    end
    check("rr_no_rsp", seen, 32'd0);
    check("rr_ready", {31'b0, req_ready}, 32'd1);

    // Back-to-back: three queued requests; the bench plays a one-cycle adder ALU.
    tbl_a[0] = 32'd10;  tbl_b[0] = 32'd20;          tbl_e[0] = 32'd30;
    tbl_a[1] = 32'd100; tbl_b[1] = 32'd1;           tbl_e[1] = 32'd101;
    tbl_a[2] = 32'd7;   tbl_b[2] = 32'hFFFF_FFF0;   tbl_e[2] = 32'hFFFF_FFF7;
    idx = 0; n_rsp = 0; pend = 0; cap_a = '0; cap_b = '0;
    for (int k = 0; k < 60; k++) begin
      if (rsp_valid) begin
        if (n_rsp < 3) check($sformatf("b2b_rsp%0d", n_rsp), rsp_data, tbl_e[n_rsp]);
        n_rsp++;
      end
      alu_valid_out = (pend != 0);
      alu_out       = cap_a + cap_b;
      pend          = 0;
      if (rs_data_valid && !rs_data_sel) cap_a = rs_data;
      if (rs_data_valid && rs_data_sel) begin
        cap_b = rs_data;
        pend  = 1;
      end
      req_valid = (idx < 3);
      if (idx < 3) begin
        req_op_code = 4'h1; req_use_imm = 1'b0;
        req_rs1 = tbl_a[idx]; req_rs2 = tbl_b[idx];
      end
      if (req_valid && req_ready) idx++;
      step();
    end
    req_valid = 1'b0;
    alu_valid_out = 1'b0;
    check("b2b_accepted", idx, 32'd3);
    check("b2b_count", n_rsp, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
